// File: rtl/cpu_debug_probe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_probe_pkg
//  Description : Shared definitions for the KS-10 debug probe. Holds the host
//                register addresses, the CTRL/STATUS bit positions and the
//                capture state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_debug_probe_pkg;

  // Host register map (5-bit address space)
  localparam logic [4:0] c_ADDR_CTRL    = 5'h00;
  localparam logic [4:0] c_ADDR_STATUS  = 5'h01;
  localparam logic [4:0] c_ADDR_PRETRIG = 5'h02;
  localparam logic [4:0] c_ADDR_RDADDR  = 5'h03;
  localparam logic [4:0] c_ADDR_RDDATA0 = 5'h04;
  localparam logic [4:0] c_ADDR_MATCH0  = 5'h08;
  localparam logic [4:0] c_ADDR_MASK0   = 5'h0C;
  localparam logic [4:0] c_ADDR_VIO_OUT = 5'h10;
  localparam logic [4:0] c_ADDR_VIO_IN  = 5'h11;

  // CTRL bits
  localparam int c_CTRL_ARM_BIT   = 0;
  localparam int c_CTRL_ABORT_BIT = 1;

  // STATUS bits
  localparam int c_STAT_ARMED_BIT = 0;
  localparam int c_STAT_TRIG_BIT  = 1;
  localparam int c_STAT_DONE_BIT  = 2;
  localparam int c_STAT_TADDR_LSB = 16;

  // Capture state machine encoding
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/cpu_debug_probe_ram.sv
`default_nettype none
// ============================================================================
//  Module      : probe_capture_ram
//  Description : Simple dual-port capture memory, DEPTH x WIDTH. One write
//                port, one synchronous registered read port, no reset.
//  Ports       : clk   - clock
//                we    - write enable
//                waddr - write address
//                wdata - write data
//                raddr - read address
//                rdata - read data, valid one cycle after raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module probe_capture_ram #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 128,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/cpu_debug_probe.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_debug_probe
//  Description : Debug probe for the KS-10 CPU. 128-bit logic-analyzer capture
//                engine with pre/post-trigger window plus a 4-bit virtual I/O
//                port, both behind one host register interface.
//  Ports       : clk, rst           - clock, async active-high reset
//                trig0[127:0]       - CPU trace word, sampled every clock
//                vio_in[3:0]        - asynchronous status input
//                vio_out[3:0]       - register select (debugADDR)
//                host_addr/we/re/wdata - host register access
//                host_rdata/rvalid  - read response, one cycle after host_re
//                ila_done           - capture complete (level)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_debug_probe
  import cpu_debug_probe_pkg::*;
#(
  parameter int         DEPTH     = 1024,
  parameter logic [3:0] VIO_RESET = 4'h1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] trig0,
  input  logic [3:0]   vio_in,
  output logic [3:0]   vio_out,
  input  logic [4:0]   host_addr,
  input  logic         host_we,
  input  logic         host_re,
  input  logic [31:0]  host_wdata,
  output logic [31:0]  host_rdata,
  output logic         host_rvalid,
  output logic         ila_done
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] c_ONE  = AW'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [127:0]      r_trig;
  cap_state_t        r_state;
  logic              r_arm_q;
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_cnt;
  logic [AW-1:0]     r_taddr;
  logic              r_triggered;
  logic              r_done;
  logic [AW-1:0]     r_pretrig;
  logic [AW-1:0]     r_rdaddr;
  logic [3:0][31:0]  r_match;
  logic [3:0][31:0]  r_mask;
  logic [3:0]        r_vio_out;
  logic [3:0]        r_vio_s1;
  logic [3:0]        r_vio_s2;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic              w_ctrl_wr;
  logic              w_arm;
  logic              w_abort;
  logic              w_hit;
  logic              w_we;
  logic              w_armed;
  logic [AW-1:0]     w_post_len;
  logic [AW-1:0]     w_raddr;
  logic [127:0]      w_ram_rdata;
  logic [3:0][31:0]  w_ram_words;
  logic [15:0]       w_taddr16;
  logic [31:0]       w_rdata;

  assign w_ctrl_wr  = host_we && (host_addr == c_ADDR_CTRL);
  assign w_abort    = w_ctrl_wr && host_wdata[c_CTRL_ABORT_BIT];
  assign w_arm      = w_ctrl_wr && host_wdata[c_CTRL_ARM_BIT] && !host_wdata[c_CTRL_ABORT_BIT];
  assign w_hit      = (((r_trig ^ r_match) & r_mask) == '0);
  assign w_we       = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  // An ARM sits in r_arm_q for one cycle before the FSM leaves IDLE; count
  // that cycle as armed so STATUS never shows a gap after an ARM write.
  assign w_armed    = w_we || r_arm_q;
  assign w_post_len = c_LAST - r_pretrig;
  // Logical index -> physical: oldest sample sits PRETRIG before the trigger
  assign w_raddr    = r_taddr - r_pretrig + r_rdaddr;
  assign w_ram_words = w_ram_rdata;
  assign w_taddr16  = 16'(r_taddr);

  assign vio_out  = r_vio_out;
  assign ila_done = r_done;

  // --------------------------------------------------------------------------
  // Capture memory
  // --------------------------------------------------------------------------
  probe_capture_ram #(
    .DEPTH (DEPTH),
    .WIDTH (128),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wptr),
    .wdata (r_trig),
    .raddr (w_raddr),
    .rdata (w_ram_rdata)
  );

  // Trace word input register; compare and memory write both use this copy
  always_ff @(posedge clk) begin
    r_trig <= trig0;
  end

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_arm_q     <= 1'b0;
      r_wptr      <= '0;
      r_cnt       <= '0;
      r_taddr     <= '0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_abort) begin
      r_state     <= ST_IDLE;
      r_arm_q     <= 1'b0;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else if (w_arm) begin
      // Park in IDLE for one cycle so the first stored sample is the trace
      // word seen on trig0 in the cycle after the ARM write.
      r_state     <= ST_IDLE;
      r_arm_q     <= 1'b1;
      r_triggered <= 1'b0;
      r_done      <= 1'b0;
    end else if (r_arm_q) begin
      r_arm_q <= 1'b0;
      r_wptr  <= '0;
      r_cnt   <= '0;
      r_state <= (r_pretrig == '0) ? ST_WAIT : ST_PRE;
    end else begin
      case (r_state)
        ST_PRE: begin
          r_wptr <= r_wptr + c_ONE;
          if (r_cnt >= r_pretrig - c_ONE) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        ST_WAIT: begin
          r_wptr <= r_wptr + c_ONE;
          if (w_hit) begin
            r_taddr     <= r_wptr;
            r_triggered <= 1'b1;
            r_cnt       <= '0;
            // PRETRIG = DEPTH-1 leaves no room for post-trigger samples
            if (w_post_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_POST;
            end
          end
        end
        ST_POST: begin
          r_wptr <= r_wptr + c_ONE;
          if (r_cnt >= w_post_len - c_ONE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_ONE;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Host register file
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pretrig <= '0;
      r_rdaddr  <= '0;
      r_match   <= '0;
      r_mask    <= '0;
      r_vio_out <= VIO_RESET;
    end else if (host_we) begin
      if (host_addr == c_ADDR_PRETRIG) begin
        // DEPTH is a power of two, so any bit at or above AW means >= DEPTH
        r_pretrig <= (|host_wdata[31:AW]) ? c_LAST : host_wdata[AW-1:0];
      end
      if (host_addr == c_ADDR_RDADDR) begin
        r_rdaddr <= host_wdata[AW-1:0];
      end
      if (host_addr[4:2] == c_ADDR_MATCH0[4:2]) begin
        r_match[host_addr[1:0]] <= host_wdata;
      end
      if (host_addr[4:2] == c_ADDR_MASK0[4:2]) begin
        r_mask[host_addr[1:0]] <= host_wdata;
      end
      if (host_addr == c_ADDR_VIO_OUT) begin
        r_vio_out <= host_wdata[3:0];
      end
    end
  end

  // vio_in two-flop synchronizer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vio_s1 <= '0;
      r_vio_s2 <= '0;
    end else begin
      r_vio_s1 <= vio_in;
      r_vio_s2 <= r_vio_s1;
    end
  end

  // Read mux
  always_comb begin
    w_rdata = '0;
    if (host_addr == c_ADDR_STATUS) begin
      w_rdata[c_STAT_TADDR_LSB +: 16] = w_taddr16;
      w_rdata[c_STAT_DONE_BIT]        = r_done;
      w_rdata[c_STAT_TRIG_BIT]        = r_triggered;
      w_rdata[c_STAT_ARMED_BIT]       = w_armed;
    end else if (host_addr == c_ADDR_PRETRIG) begin
      w_rdata[AW-1:0] = r_pretrig;
    end else if (host_addr == c_ADDR_RDADDR) begin
      w_rdata[AW-1:0] = r_rdaddr;
    end else if (host_addr[4:2] == c_ADDR_RDDATA0[4:2]) begin
      w_rdata = w_ram_words[host_addr[1:0]];
    end else if (host_addr[4:2] == c_ADDR_MATCH0[4:2]) begin
      w_rdata = r_match[host_addr[1:0]];
    end else if (host_addr[4:2] == c_ADDR_MASK0[4:2]) begin
      w_rdata = r_mask[host_addr[1:0]];
    end else if (host_addr == c_ADDR_VIO_OUT) begin
      w_rdata[3:0] = r_vio_out;
    end else if (host_addr == c_ADDR_VIO_IN) begin
      w_rdata[3:0] = r_vio_s2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      host_rvalid <= host_re;
      if (host_re) begin
        host_rdata <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_debug_probe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_debug_probe
//  Description : Directed self-checking bench for cpu_debug_probe. The trace
//                word is a free-running counter advanced on the falling edge;
//                captures are read back through the host register interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_debug_probe;

  localparam int D = 1024;

  logic         clk;
  logic         rst;
  logic [127:0] trig0;
  logic [3:0]   vio_in;
  logic [3:0]   vio_out;
  logic [4:0]   host_addr;
  logic         host_we;
  logic         host_re;
  logic [31:0]  host_wdata;
  logic [31:0]  host_rdata;
  logic         host_rvalid;
  logic         ila_done;

  logic [31:0]  ctr;
  logic [31:0]  rdv;
  logic [31:0]  v0;
  logic         last_rv;
  int           n_checks;
  int           n_errors;

  assign trig0 = {96'h0, ctr};

  cpu_debug_probe #(
    .DEPTH     (D),
    .VIO_RESET (4'h1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig0       (trig0),
    .vio_in      (vio_in),
    .vio_out     (vio_out),
    .host_addr   (host_addr),
    .host_we     (host_we),
    .host_re     (host_re),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .ila_done    (ila_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Trace counter: one step per cycle, stable around each rising edge
  initial begin
    ctr = '0;
    forever begin
      @(negedge clk);
      ctr = ctr + 32'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    @(negedge clk);
    host_we    = 1'b0;
  endtask

  // ARM write; returns the counter value present at the ARM edge and can
  // optionally reload the counter so that the first stored sample is 0.
  task automatic arm(input bit reload, output logic [31:0] v);
    @(negedge clk);
    host_addr  = 5'h00;
    host_wdata = 32'h1;
    host_we    = 1'b1;
    @(posedge clk);
    v = ctr;
    #1;
    if (reload) ctr = 32'hFFFF_FFFF;
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk);
    host_addr = a;
    host_re   = 1'b1;
    @(negedge clk);
    host_re   = 1'b0;
    d         = host_rdata;
    last_rv   = host_rvalid;
  endtask

  task automatic rd_sample(input int idx, output logic [31:0] d);
    wr(5'h03, 32'(idx));
    @(negedge clk);
    rd(5'h04, d);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ila_done) break;
      @(negedge clk);
    end
    chk("done_reached", {31'b0, ila_done}, 32'h1);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    vio_in     = 4'h0;
    host_addr  = '0;
    host_we    = 1'b0;
    host_re    = 1'b0;
    host_wdata = '0;
    repeat (4) @(negedge clk);

    // ---------------- Reset state ----------------
    chk("rst_vio_out", {28'b0, vio_out}, 32'h1);
    chk("rst_ila_done", {31'b0, ila_done}, 32'h0);
    chk("rst_rvalid", {31'b0, host_rvalid}, 32'h0);
    chk("rst_rdata", host_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd(5'h01, rdv);
    chk("rst_status", rdv, 32'h0);
    chk("rvalid_after_re", {31'b0, last_rv}, 32'h1);
    rd(5'h1F, rdv);
    chk("unmapped_read", rdv, 32'h0);
    rd(5'h00, rdv);
    chk("ctrl_read", rdv, 32'h0);

    // ---------------- Mask 0, PRETRIG 0: trigger at once ----------------
    arm(1'b0, v0);
    wait_done(D + 50);
    rd(5'h01, rdv);
    chk("t1_status", rdv, 32'h0000_0006);
    rd_sample(0, rdv);
    chk("t1_idx0", rdv, v0 + 32'd1);
    rd_sample(1, rdv);
    chk("t1_idx1", rdv, v0 + 32'd2);
    rd_sample(500, rdv);
    chk("t1_idx500", rdv, v0 + 32'd501);
    rd_sample(D - 1, rdv);
    chk("t1_idx_last", rdv, v0 + 32'd1024);

    // ---------------- Match 100, PRETRIG 8 ----------------
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h08, 32'd100);
    wr(5'h02, 32'd8);
    arm(1'b1, v0);
    wait_done(D + 200);
    rd(5'h01, rdv);
    chk("t2_status", rdv, 32'h0064_0006);
    rd_sample(8, rdv);
    chk("t2_idx8", rdv, 32'd100);
    rd_sample(0, rdv);
    chk("t2_idx0", rdv, 32'd92);
    rd_sample(D - 1, rdv);
    chk("t2_idx_last", rdv, 32'd1115);

    // ---------------- ABORT mid-WAIT, then re-ARM ----------------
    wr(5'h08, 32'hDEAD_BEEF);
    arm(1'b1, v0);
    repeat (40) @(negedge clk);
    rd(5'h01, rdv);
    chk("t3_waiting", rdv & 32'h7, 32'h1);
    wr(5'h00, 32'h2);
    rd(5'h01, rdv);
    chk("t3_aborted", rdv & 32'h7, 32'h0);
    chk("t3_done_low", {31'b0, ila_done}, 32'h0);
    wr(5'h08, 32'd100);
    arm(1'b1, v0);
    wait_done(D + 200);
    rd_sample(8, rdv);
    chk("t3_rearm_idx8", rdv, 32'd100);
    rd_sample(0, rdv);
    chk("t3_rearm_idx0", rdv, 32'd92);
    // ARM and ABORT together: ABORT wins, probe stays idle
    wr(5'h00, 32'h3);
    repeat (3) @(negedge clk);
    rd(5'h01, rdv);
    chk("t3_abort_prio", rdv & 32'h7, 32'h0);

    // ---------------- VIO ----------------
    wr(5'h10, 32'hA);
    chk("vio_out_A", {28'b0, vio_out}, 32'hA);
    rd(5'h10, rdv);
    chk("vio_out_reg", rdv, 32'hA);
    @(negedge clk);
    vio_in = 4'h5;
    repeat (3) @(negedge clk);
    rd(5'h11, rdv);
    chk("vio_in_sync", rdv, 32'h5);

    // ---------------- PRETRIG clamp ----------------
    wr(5'h02, 32'd2000);
    rd(5'h02, rdv);
    chk("pretrig_clamp", rdv, 32'd1023);
    wr(5'h0C, 32'h0);
    arm(1'b0, v0);
    wait_done(D + 50);
    rd(5'h01, rdv);
    chk("t5_status", rdv, 32'h03FF_0006);
    rd_sample(0, rdv);
    chk("t5_idx0", rdv, v0 + 32'd1);
    rd_sample(D - 1, rdv);
    chk("t5_idx_trig", rdv, v0 + 32'd1024);

    // ---------------- Reset mid-POST ----------------
    wr(5'h02, 32'd4);
    arm(1'b0, v0);
    repeat (20) @(negedge clk);
    rd(5'h01, rdv);
    chk("t6_in_post", rdv & 32'h7, 32'h3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_vio_out", {28'b0, vio_out}, 32'h1);
    chk("t6_done", {31'b0, ila_done}, 32'h0);
    rd(5'h01, rdv);
    chk("t6_status", rdv, 32'h0);
    rd(5'h02, rdv);
    chk("t6_pretrig", rdv, 32'h0);
    repeat (D + 20) @(negedge clk);
    chk("t6_stays_idle", {31'b0, ila_done}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
